// File: rtl/product_accumulator_pkg.sv
//==============================================================================
// Module      : product_acc_pkg
// Description : Shared constants, FSM encoding and width helpers for the
//               product accumulator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package product_acc_pkg;

  localparam int   GROUPS          = 4;
  localparam int   DEF_NUM_WIDTH   = 8;
  localparam int   DEF_PW          = 2 * DEF_NUM_WIDTH;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  function automatic int prod_width(input int num_width);
    return 2 * num_width;
  endfunction

  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Worst-case beat sum must fit in the accumulator without wrapping.
  function automatic bit acc_width_ok(input int acc_width, input int pw, input int lanes);
    return acc_width >= pw + ceil_log2(lanes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/product_accumulator_if.sv
//==============================================================================
// Module      : product_acc_if
// Description : Product-beat input and sum-result output handshakes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface product_acc_if #(
  parameter int ARRAY_SIZE = 16,
  parameter int NUM_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
);

  logic                              in_valid;
  logic                              in_ready;
  logic [2*NUM_WIDTH*ARRAY_SIZE-1:0] in_products;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [ACC_WIDTH-1:0]              out_sum;
  logic [CNT_WIDTH-1:0]              out_beats;
  logic                              out_ovf;

  modport master (
    output in_valid, in_products, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_products, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_beats, out_ovf
  );

endinterface

`default_nettype wire

// File: rtl/product_accumulator_group_adder.sv
//==============================================================================
// Module      : group_adder
// Description : Registered sum of LANES zero-extended products; valid passes
//               through alongside.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module group_adder #(
  parameter int LANES     = 4,
  parameter int PW        = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [LANES*PW-1:0]   in_lanes,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  out_sum
);

  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] r_sum;
  logic                 r_valid;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + ACC_WIDTH'(in_lanes[i*PW +: PW]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_sum <= w_sum;
    end
  end

  assign out_valid = r_valid;
  assign out_sum   = r_sum;

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
//==============================================================================
// Module      : product_accumulator
// Description : Reduces product beats through a 2-stage adder tree and folds
//               them into a per-vector sum. Saturation: PRODUCT_ACC_SATURATE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int NUM_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  product_acc_if.slave bus
);

  localparam int PW = prod_width(NUM_WIDTH);
  localparam int GL = ARRAY_SIZE / GROUPS;

  if (((ARRAY_SIZE % GROUPS) != 0) || !acc_width_ok(ACC_WIDTH, PW, ARRAY_SIZE)) begin : g_bad_cfg
    $error("product_accumulator: illegal ARRAY_SIZE/ACC_WIDTH combination");
  end

  logic [1:0]           r_state;
  logic                 w_accept;
  logic                 w_handshake;

  logic [GROUPS-1:0]    w_s1_valid_vec;
  logic [ACC_WIDTH-1:0] w_s1_sum [GROUPS];
  logic                 w_s1_valid;
  logic                 r_s1_last;

  logic [ACC_WIDTH-1:0] w_s2_sum;
  logic [ACC_WIDTH-1:0] r_s2_sum;
  logic                 r_s2_valid;
  logic                 r_s2_last;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic                 r_s3_last_done;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_ovf_next;

  assign w_accept    = bus.in_valid && (r_state == ST_ACCUM);
  assign w_handshake = (r_state == ST_HOLD) && bus.out_ready;

  // Stage 1: four parallel group sums
  for (genvar g = 0; g < GROUPS; g++) begin : g_group
    group_adder #(
      .LANES     (GL),
      .PW        (PW),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_group_adder (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w_accept),
      .in_lanes  (bus.in_products[g*GL*PW +: GL*PW]),
      .out_valid (w_s1_valid_vec[g]),
      .out_sum   (w_s1_sum[g])
    );
  end

  assign w_s1_valid = &w_s1_valid_vec;

  always_ff @(posedge clk) begin
    if (reset) r_s1_last <= 1'b0;
    else       r_s1_last <= w_accept && bus.in_last;
  end

  // Stage 2: beat sum
  always_comb begin
    w_s2_sum = '0;
    for (int g = 0; g < GROUPS; g++) begin
      w_s2_sum = w_s2_sum + w_s1_sum[g];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_sum   <= '0;
    end else begin
      r_s2_valid <= w_s1_valid;
      r_s2_last  <= w_s1_valid && r_s1_last;
      if (w_s1_valid) r_s2_sum <= w_s2_sum;
    end
  end

  // Stage 3: accumulate
`ifdef PRODUCT_ACC_SATURATE_EN
  logic [ACC_WIDTH:0] w_acc_wide;
  assign w_acc_wide = {1'b0, r_acc} + {1'b0, r_s2_sum};

  always_comb begin
    w_acc_next = w_acc_wide[ACC_WIDTH-1:0];
    w_ovf_next = r_ovf;
    if (r_ovf || w_acc_wide[ACC_WIDTH]) begin
      w_acc_next = '1;
      w_ovf_next = 1'b1;
    end
  end
`else
  always_comb begin
    w_acc_next = r_acc + r_s2_sum;
    w_ovf_next = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || w_handshake) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_s3_last_done <= 1'b0;
    end else begin
      r_s3_last_done <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= w_ovf_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_accept && bus.in_last) r_state <= ST_DRAIN;
        ST_DRAIN: if (r_s3_last_done)          r_state <= ST_HOLD;
        ST_HOLD:  if (bus.out_ready)           r_state <= ST_ACCUM;
        default:                               r_state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.out_sum   = r_acc;
  assign bus.out_beats = r_cnt;
  assign bus.out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
//==============================================================================
// Module      : tb_product_accumulator
// Description : Directed self-checking bench for product_accumulator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_product_accumulator;

  localparam int W = 256;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  product_acc_if #(.ARRAY_SIZE(16), .NUM_WIDTH(8), .ACC_WIDTH(32), .CNT_WIDTH(16)) bus ();
  product_acc_if #(.ARRAY_SIZE(16), .NUM_WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(16)) bus20 ();

  product_accumulator #(.ARRAY_SIZE(16), .NUM_WIDTH(8), .ACC_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  product_accumulator #(.ARRAY_SIZE(16), .NUM_WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(16)) dut20 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] make_all(input logic [15:0] v);
    logic [W-1:0] p;
    for (int i = 0; i < 16; i++) p[i*16 +: 16] = v;
    return p;
  endfunction

  function automatic logic [W-1:0] make_lane0(input logic [15:0] v);
    logic [W-1:0] p;
    p = '0;
    p[15:0] = v;
    return p;
  endfunction

  // Present one beat at a negedge; returns at the negedge after it is taken.
  task automatic beat(input logic [W-1:0] p, input logic last);
    bus.in_valid    = 1'b1;
    bus.in_products = p;
    bus.in_last     = last;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_sum !== 32'd0)   begin errors++; $display("FAIL reset_out_sum got=%0d exp=0", bus.out_sum); end
    checks++; if (bus.out_beats !== 16'd0) begin errors++; $display("FAIL reset_out_beats got=%0d exp=0", bus.out_beats); end
    checks++; if (bus.out_ovf !== 1'b0)    begin errors++; $display("FAIL reset_out_ovf got=%0b exp=0", bus.out_ovf); end
  endtask

  task automatic test_single_beat();
    beat(make_all(16'd1), 1'b1);
    idle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid cyc=%0d got=%0b exp=0", k, bus.out_valid); end
      @(negedge clk);
    end
    checks++; if (bus.out_valid !== 1'b1)  begin errors++; $display("FAIL single_latency got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_sum !== 32'd16)  begin errors++; $display("FAIL single_sum got=%0d exp=16", bus.out_sum); end
    checks++; if (bus.out_beats !== 16'd1) begin errors++; $display("FAIL single_beats got=%0d exp=1", bus.out_beats); end
    checks++; if (bus.out_ovf !== 1'b0)    begin errors++; $display("FAIL single_ovf got=%0b exp=0", bus.out_ovf); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_release got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int waited;
    for (int b = 0; b < 4; b++) beat(make_all(16'd65025), (b == 3));
    idle();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_last got=%0b exp=0", bus.in_ready); end
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drain got=%0b exp=0", bus.in_ready); end
      @(negedge clk);
      waited++;
    end
    checks++; if (bus.out_valid !== 1'b1)      begin errors++; $display("FAIL b2b_timeout got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_sum !== 32'd4161600) begin errors++; $display("FAIL b2b_sum got=%0d exp=4161600", bus.out_sum); end
    checks++; if (bus.out_beats !== 16'd4)     begin errors++; $display("FAIL b2b_beats got=%0d exp=4", bus.out_beats); end
    checks++; if (bus.in_ready !== 1'b0)       begin errors++; $display("FAIL b2b_ready_hold got=%0b exp=0", bus.in_ready); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL b2b_ready_back got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_backpressure();
    int waited;
    beat(make_all(16'd3), 1'b1);
    idle();
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got=%0b exp=1", bus.out_valid); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.out_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid cyc=%0d got=%0b exp=1", k, bus.out_valid); end
      checks++; if (bus.out_sum !== 32'd48)  begin errors++; $display("FAIL bp_sum cyc=%0d got=%0d exp=48", k, bus.out_sum); end
      checks++; if (bus.out_beats !== 16'd1) begin errors++; $display("FAIL bp_beats cyc=%0d got=%0d exp=1", k, bus.out_beats); end
      checks++; if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", k, bus.in_ready); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL bp_ready_back got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_bubbles();
    int waited;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      beat(make_lane0(16'd100), (b == 2));
      idle();
      if (b < 2) repeat (2) @(negedge clk);
    end
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    checks++; if (bus.out_valid !== 1'b1)  begin errors++; $display("FAIL bub_timeout got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_sum !== 32'd300) begin errors++; $display("FAIL bub_sum got=%0d exp=300", bus.out_sum); end
    checks++; if (bus.out_beats !== 16'd3) begin errors++; $display("FAIL bub_beats got=%0d exp=3", bus.out_beats); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bub_release got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_vector();
    int waited;
    beat(make_all(16'd7), 1'b0);
    beat(make_all(16'd9), 1'b0);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%0b exp=0", bus.out_valid); end
    beat(make_all(16'd2), 1'b1);
    idle();
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    checks++; if (bus.out_valid !== 1'b1)  begin errors++; $display("FAIL rstmid_timeout got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_sum !== 32'd32)  begin errors++; $display("FAIL rstmid_sum got=%0d exp=32", bus.out_sum); end
    checks++; if (bus.out_beats !== 16'd1) begin errors++; $display("FAIL rstmid_beats got=%0d exp=1", bus.out_beats); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int          waited;
    logic [19:0] exp_sum;
    logic        exp_ovf;
`ifdef PRODUCT_ACC_SATURATE_EN
    exp_sum = 20'd1048575;
    exp_ovf = 1'b1;
`else
    exp_sum = 20'd1032224;
    exp_ovf = 1'b0;
`endif
    for (int b = 0; b < 2; b++) begin
      bus20.in_valid    = 1'b1;
      bus20.in_products = make_all(16'd65025);
      bus20.in_last     = (b == 1);
      @(negedge clk);
    end
    bus20.in_valid = 1'b0;
    bus20.in_last  = 1'b0;
    waited = 0;
    while (bus20.out_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    checks++; if (bus20.out_valid !== 1'b1)  begin errors++; $display("FAIL sat_timeout got=%0b exp=1", bus20.out_valid); end
    checks++; if (bus20.out_sum !== exp_sum) begin errors++; $display("FAIL sat_sum got=%0d exp=%0d", bus20.out_sum, exp_sum); end
    checks++; if (bus20.out_ovf !== exp_ovf) begin errors++; $display("FAIL sat_ovf got=%0b exp=%0b", bus20.out_ovf, exp_ovf); end
    checks++; if (bus20.out_beats !== 16'd2) begin errors++; $display("FAIL sat_beats got=%0d exp=2", bus20.out_beats); end
    bus20.out_ready = 1'b1;
    @(negedge clk);
    bus20.out_ready = 1'b0;
    checks++; if (bus20.out_ovf !== 1'b0)   begin errors++; $display("FAIL sat_ovf_clear got=%0b exp=0", bus20.out_ovf); end
    checks++; if (bus20.out_valid !== 1'b0) begin errors++; $display("FAIL sat_release got=%0b exp=0", bus20.out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_products   = '0;
    bus.in_last       = 1'b0;
    bus.out_ready     = 1'b0;
    bus20.in_valid    = 1'b0;
    bus20.in_products = '0;
    bus20.in_last     = 1'b0;
    bus20.out_ready   = 1'b0;

    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_mid_vector();
    test_saturation();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
